// File: rtl/alu8_seq_if.sv
// Bus bundle between the control path / ALU and alu8_sequencer.
// ALU8_SEQ_FLAGS_EN adds the zero/negative result flags to the bundle.
interface alu8_seq_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [AW-1:0]     cmd_dst;
    logic [AW-1:0]     cmd_src_a;
    logic [AW-1:0]     cmd_src_b;
    logic              cmd_imm_en;
    logic [DATA_W-1:0] cmd_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_r;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [AW-1:0]     res_dst;

    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

`ifdef ALU8_SEQ_FLAGS_EN
    logic              flag_z;
    logic              flag_n;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
        input  alu_r, rd_addr,
        output cmd_ready, alu_a, alu_b, alu_op,
        output res_valid, res_data, res_dst, rd_data, flag_z, flag_n
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
        output alu_r, rd_addr,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  res_valid, res_data, res_dst, rd_data, flag_z, flag_n
    );
`else
    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
        input  alu_r, rd_addr,
        output cmd_ready, alu_a, alu_b, alu_op,
        output res_valid, res_data, res_dst, rd_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
        output alu_r, rd_addr,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  res_valid, res_data, res_dst, rd_data
    );
`endif

endinterface

// File: rtl/alu8_sequencer.sv
// Register-file command sequencer driving an external 8-bit combinational ALU (IDLE->EXEC->WB).
// Optional feature macro: ALU8_SEQ_FLAGS_EN (registered zero/negative flags at writeback).
module alu8_sequencer #(
    parameter int DATA_W   = 8,
    parameter int RF_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu8_seq_if.slave  bus
);
    localparam int AW = $clog2(RF_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state_reg;
    logic              cmd_ready_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [2:0]        alu_op_reg;
    logic [AW-1:0]     dst_reg;
    logic              res_valid_reg;
    logic [DATA_W-1:0] res_data_reg;
    logic [AW-1:0]     res_dst_reg;

    logic              accept;
    logic              wb_en;
    logic [DATA_W-1:0] rf_word [RF_DEPTH];

    assign accept = bus.cmd_valid && cmd_ready_reg;
    assign wb_en  = (state_reg == EXEC);

    // One register per entry; each only loads when the EXEC-cycle destination selects it.
    generate
        for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : rf_gen
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (wb_en && (dst_reg == AW'(gi))) begin
                    entry_reg <= bus.alu_r;
                end
            end

            assign rf_word[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            dst_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_dst_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_a_reg     <= rf_word[bus.cmd_src_a];
                        alu_b_reg     <= bus.cmd_imm_en ? bus.cmd_imm : rf_word[bus.cmd_src_b];
                        alu_op_reg    <= bus.cmd_op;
                        dst_reg       <= bus.cmd_dst;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_reg  <= bus.alu_r;
                    res_dst_reg   <= dst_reg;
                    res_valid_reg <= 1'b1;
                    state_reg     <= WB;
                end
                WB: begin
                    res_valid_reg <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    res_valid_reg <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU8_SEQ_FLAGS_EN
    logic flag_z_reg;
    logic flag_n_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
        end else if (wb_en) begin
            flag_z_reg <= (bus.alu_r == '0);
            flag_n_reg <= bus.alu_r[DATA_W-1];
        end
    end

    assign bus.flag_z = flag_z_reg;
    assign bus.flag_n = flag_n_reg;
`endif

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.alu_op    = alu_op_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign bus.res_dst   = res_dst_reg;
    assign bus.rd_data   = rf_word[bus.rd_addr];

endmodule

// File: tb/tb_alu8_sequencer.sv
// Directed bench for alu8_sequencer with a behavioural 8-bit ALU on the alu_* bus.
// Flag checks are included when ALU8_SEQ_FLAGS_EN is defined.
module tb_alu8_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu8_seq_if bus ();

    alu8_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: ADD, SUB, NOT A, NAND, NOR, AND, OR, XOR
    always_comb begin
        bus.alu_r = 8'h00;
        case (bus.alu_op)
            3'd0: bus.alu_r = bus.alu_a + bus.alu_b;
            3'd1: bus.alu_r = bus.alu_a - bus.alu_b;
            3'd2: bus.alu_r = ~bus.alu_a;
            3'd3: bus.alu_r = ~(bus.alu_a & bus.alu_b);
            3'd4: bus.alu_r = ~(bus.alu_a | bus.alu_b);
            3'd5: bus.alu_r = bus.alu_a & bus.alu_b;
            3'd6: bus.alu_r = bus.alu_a | bus.alu_b;
            default: bus.alu_r = bus.alu_a ^ bus.alu_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        bus.rd_addr = addr;
        #1;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic chk_flags(input string tag, input logic ez, input logic en);
`ifdef ALU8_SEQ_FLAGS_EN
        chk({tag, "_flag_z"}, {7'd0, bus.flag_z}, {7'd0, ez});
        chk({tag, "_flag_n"}, {7'd0, bus.flag_n}, {7'd0, en});
`else
        if (ez === 1'bx || en === 1'bx) $display("note %s flags unknown", tag);
`endif
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                           input logic [1:0] b, input logic imm_en, input logic [7:0] imm);
        bus.cmd_op     = op;
        bus.cmd_dst    = dst;
        bus.cmd_src_a  = a;
        bus.cmd_src_b  = b;
        bus.cmd_imm_en = imm_en;
        bus.cmd_imm    = imm;
    endtask

    // Full accept -> EXEC -> WB -> IDLE transaction with checks in every phase.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] a, input logic [1:0] b, input logic imm_en,
                           input logic [7:0] imm, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] er, input logic ez, input logic en);
        set_cmd(op, dst, a, b, imm_en, imm);
        chk({tag, "_ready_idle"}, {7'd0, bus.cmd_ready}, 8'd1);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk({tag, "_ready_exec"}, {7'd0, bus.cmd_ready}, 8'd0);
        chk({tag, "_alu_a"}, bus.alu_a, ea);
        chk({tag, "_alu_b"}, bus.alu_b, eb);
        chk({tag, "_alu_op"}, {5'd0, bus.alu_op}, {5'd0, op});
        chk({tag, "_valid_exec"}, {7'd0, bus.res_valid}, 8'd0);
        tick();
        chk({tag, "_valid_wb"}, {7'd0, bus.res_valid}, 8'd1);
        chk({tag, "_res_data"}, bus.res_data, er);
        chk({tag, "_res_dst"}, {6'd0, bus.res_dst}, {6'd0, dst});
        chk_flags(tag, ez, en);
        chk_rf({tag, "_rf_dst"}, dst, er);
        tick();
        chk({tag, "_valid_idle"}, {7'd0, bus.res_valid}, 8'd0);
        chk({tag, "_ready_back"}, {7'd0, bus.cmd_ready}, 8'd1);
        chk({tag, "_res_held"}, bus.res_data, er);
        $display("txn %s op=%0d dst=%0d a=0x%02h b=0x%02h r=0x%02h", tag, op, dst,
                 bus.alu_a, bus.alu_b, bus.res_data);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rd_addr   = 2'd0;
        set_cmd(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {7'd0, bus.cmd_ready}, 8'd1);
        chk("rst_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("rst_data", bus.res_data, 8'h00);
        chk("rst_alu_a", bus.alu_a, 8'h00);
        chk_flags("rst", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk_rf($sformatf("rst_rf%0d", i), 2'(i), 8'h00);
        $display("txn reset done");

        // Immediate load and register-register arithmetic
        run_cmd("ld_r1", 3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0);
        run_cmd("ld_r2", 3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'hFB, 8'h00, 8'hFB, 8'hFB, 1'b0, 1'b1);
        run_cmd("add_wrap", 3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'h00, 1'b1, 1'b0);
        run_cmd("sub", 3'd1, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'h0A, 1'b0, 1'b0);
        run_cmd("not_a", 3'd2, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'hFA, 1'b0, 1'b1);

        // Logic ops
        run_cmd("nand", 3'd3, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'hFE, 1'b0, 1'b1);
        run_cmd("nor", 3'd4, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'h00, 1'b1, 1'b0);
        run_cmd("and", 3'd5, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'h01, 1'b0, 1'b0);
        run_cmd("or", 3'd6, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'hFF, 1'b0, 1'b1);
        run_cmd("xor", 3'd7, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'hFE, 1'b0, 1'b1);

        // cmd_valid held high across two commands: r1 += 1, then r0 = r1 + 0x10
        set_cmd(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01);
        bus.cmd_valid = 1'b1;
        tick();
        chk("b2b_acc1_ready", {7'd0, bus.cmd_ready}, 8'd0);
        chk("b2b_acc1_alu_a", bus.alu_a, 8'h05);
        chk("b2b_acc1_alu_b", bus.alu_b, 8'h01);
        set_cmd(3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h10);
        tick();
        chk("b2b_wb1_ready", {7'd0, bus.cmd_ready}, 8'd0);
        chk("b2b_wb1_valid", {7'd0, bus.res_valid}, 8'd1);
        chk("b2b_wb1_data", bus.res_data, 8'h06);
        tick();
        chk("b2b_idle_ready", {7'd0, bus.cmd_ready}, 8'd1);
        chk("b2b_idle_alu_a_hold", bus.alu_a, 8'h05);
        chk("b2b_idle_alu_b_hold", bus.alu_b, 8'h01);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_acc2_ready", {7'd0, bus.cmd_ready}, 8'd0);
        chk("b2b_acc2_alu_a", bus.alu_a, 8'h06);
        chk("b2b_acc2_alu_b", bus.alu_b, 8'h10);
        tick();
        chk("b2b_wb2_valid", {7'd0, bus.res_valid}, 8'd1);
        chk("b2b_wb2_data", bus.res_data, 8'h16);
        chk("b2b_wb2_dst", {6'd0, bus.res_dst}, 8'd0);
        chk_rf("b2b_rf0", 2'd0, 8'h16);
        tick();
        chk("b2b_end_valid", {7'd0, bus.res_valid}, 8'd0);
        $display("txn back-to-back r1=0x06 r0=0x16");

        // Reset during EXEC of a write to r2 aborts it
        set_cmd(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("abort_exec_ready", {7'd0, bus.cmd_ready}, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("abort_ready", {7'd0, bus.cmd_ready}, 8'd1);
        chk("abort_res_data", bus.res_data, 8'h00);
        chk("abort_alu_a", bus.alu_a, 8'h00);
        chk_rf("abort_rf2", 2'd2, 8'h00);
        tick();
        chk("abort_valid_next", {7'd0, bus.res_valid}, 8'd0);
        $display("txn reset-abort");

        run_cmd("post_rst", 3'd7, 2'd2, 2'd0, 2'd0, 1'b1, 8'hAA, 8'h00, 8'hAA, 8'hAA, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
